// File: rtl/result_drain_pkg.sv
// Shared widths, FSM state encodings and helpers for the result drain stage.
package result_drain_pkg;

    localparam int unsigned EXTEND_WORD_SIZE = 16;
    localparam int unsigned GBUFF_INDX_SIZE  = 8;
    localparam int unsigned DIM_W            = 4;
    localparam int unsigned TOTAL_W          = 8;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_RUN   = 2'd1,
        DRAIN_FLUSH = 2'd2,
        DRAIN_DONE  = 2'd3
    } drain_state_e;

    // Number of result words for an m x n matrix (max 15*15 = 225 fits in 8 bits).
    function automatic logic [TOTAL_W-1:0] drain_total(input logic [DIM_W-1:0] rows,
                                                       input logic [DIM_W-1:0] cols);
        return TOTAL_W'(rows) * TOTAL_W'(cols);
    endfunction

endpackage

// File: rtl/result_drain_fifo.sv
// First-word-fall-through synchronous FIFO buffering words returned by GBUFF_OUT.
module drain_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_c;
    logic             pop_ok_c;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok_c  = pop && (count_q != '0);
    assign push_ok_c = push && ((count_q < CNT_W'(DEPTH)) || pop_ok_c);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop_ok_c) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/result_drain.sv
// Reads the m x n result matrix out of GBUFF_OUT in row-major order and streams it on valid/ready.
module result_drain
    import result_drain_pkg::*;
#(
    parameter int unsigned DATA_W     = EXTEND_WORD_SIZE,
    parameter int unsigned IDX_W      = GBUFF_INDX_SIZE,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    output logic [IDX_W-1:0]  gb_index,
    output logic              gb_wr_en,
    input  logic [DATA_W-1:0] gb_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CR_W  = CNT_W + 1;

    drain_state_e       state_q, state_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [TOTAL_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               inflight_q, inflight_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop_c;
    logic               rd_issue_c;
    logic [CR_W-1:0]    credit_c;
    logic               drained_c;

    drain_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (inflight_q),
        .push_data (gb_data),
        .pop       (pop_c),
        .head      (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign pop_c = !fifo_empty && out_ready;

    // Words buffered plus the read in flight, after this cycle's pop, bound the next issue.
    assign credit_c  = CR_W'(fifo_count) + CR_W'(inflight_q) - CR_W'(pop_c);
    assign drained_c = !inflight_q && ((CR_W'(fifo_count) - CR_W'(pop_c)) == '0);

    always_comb begin
        state_d    = state_q;
        total_d    = total_q;
        beat_cnt_d = beat_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_issue_c = 1'b0;

        if (pop_c) begin
            beat_cnt_d = beat_cnt_q + TOTAL_W'(1);
        end

        case (state_q)
            DRAIN_IDLE: begin
                if (start) begin
                    total_d    = drain_total(m, n);
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (total_d == '0) ? DRAIN_DONE : DRAIN_RUN;
                end
            end
            DRAIN_RUN: begin
                if (credit_c < CR_W'(FIFO_DEPTH)) begin
                    rd_issue_c = 1'b1;
                    rd_ptr_d   = rd_ptr_q + IDX_W'(1);
                    if (rd_ptr_q == IDX_W'(total_q - TOTAL_W'(1))) begin
                        state_d = DRAIN_FLUSH;
                    end
                end
            end
            DRAIN_FLUSH: begin
                if (drained_c) begin
                    state_d = DRAIN_DONE;
                end
            end
            DRAIN_DONE: begin
                state_d = DRAIN_IDLE;
            end
            default: begin
                state_d = DRAIN_IDLE;
            end
        endcase

        inflight_d = rd_issue_c;
        // An empty drain reports busy for its single DONE cycle; otherwise busy ends as done rises.
        busy_d     = (state_d == DRAIN_RUN) || (state_d == DRAIN_FLUSH) ||
                     ((state_d == DRAIN_DONE) && (total_d == '0));
        done_d     = (state_d == DRAIN_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= DRAIN_IDLE;
            total_q    <= '0;
            beat_cnt_q <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            total_q    <= total_d;
            beat_cnt_q <= beat_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign gb_index  = rd_ptr_q;
    assign gb_wr_en  = 1'b0;
    assign out_valid = !fifo_empty;
    assign out_last  = out_valid && (beat_cnt_q == (total_q - TOTAL_W'(1)));
    assign busy      = busy_q;
    assign done      = done_q;

    no_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(fifo_full && inflight_q && !pop_c));

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: vector table, reset/abort sequence and randomized drains.
module tb_result_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  m;
    logic [3:0]  n;
    logic [7:0]  gb_index;
    logic        gb_wr_en;
    logic [15:0] gb_data;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [15:0] gbuf [256];
    int          errors = 0;
    int          checks = 0;
    string       tag = "reset";

    result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .m         (m),
        .n         (n),
        .gb_index  (gb_index),
        .gb_wr_en  (gb_wr_en),
        .gb_data   (gb_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // GBUFF_OUT model: registered read, data valid the cycle after the index.
    always @(posedge clk) gb_data <= gbuf[gb_index];

    typedef struct {
        int    m;
        int    n;
        int    mode;       // 0: ready always, 1: ready 1,0,0 repeating, 2: random
        int    extra;      // cycle of an extra start pulse, -1 for none
        int    exp_beats;
        int    exp_done;   // cycle of done, -1 when not fixed
        string name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%s]: got %0d expected %0d at t=%0t", name, tag, act, exp, $time);
        end
    endtask

    task automatic zero_chk(input string name);
        chk({name, "_valid"}, 32'(out_valid), 0);
        chk({name, "_last"},  32'(out_last),  0);
        chk({name, "_busy"},  32'(busy),      0);
        chk({name, "_done"},  32'(done),      0);
        chk({name, "_wr_en"}, 32'(gb_wr_en),  0);
        chk({name, "_index"}, 32'(gb_index),  0);
        chk({name, "_data"},  32'(out_data),  0);
    endtask

    // Runs one drain with start in cycle 0; the expected stream is gbuf[0..m*n-1] in order.
    task automatic run_drain(input int mi, input int ni, input int mode, input int extra,
                             output int beats, output int done_cyc);
        int          total;
        int          acc;
        int          last_hs;
        int          dones;
        int          end_k;
        logic        v;
        logic        l;
        logic [15:0] d;
        logic        stall;
        logic [15:0] pd;
        logic        pl;
        logic        exp_busy;
        logic        exp_done;
        total    = mi * ni;
        acc      = 0;
        last_hs  = -1;
        dones    = 0;
        done_cyc = -1;
        stall    = 1'b0;
        pd       = '0;
        pl       = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            v = out_valid;
            d = out_data;
            l = out_last;
            exp_busy = (total > 0) ? (k >= 1 && acc < total) : (k == 1);
            exp_done = (total > 0) ? (k >= 1 && acc == total && k == last_hs + 1) : (k == 1);
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("gb_wr_en", 32'(gb_wr_en), 0);
            if (done) begin
                dones++;
                done_cyc = k;
            end
            if (k < 3) chk("early_valid", 32'(v), 0);
            if (mode == 0) chk("valid_timing", 32'(v), 32'(k >= 3 && k < 3 + total));
            if (total == 0 && k >= 1) chk("gb_index_held", 32'(gb_index), 0);
            if (stall) begin
                chk("stall_valid", 32'(v), 1);
                chk("stall_data",  32'(d), 32'(pd));
                chk("stall_last",  32'(l), 32'(pl));
            end
            if (v) begin
                if (acc < total) begin
                    chk("data", 32'(d), 32'(gbuf[acc]));
                    chk("last", 32'(l), 32'(acc == total - 1));
                end else begin
                    chk("extra_beat", 32'(v), 0);
                end
            end
            start = (k == 0) || (k == extra);
            if (k == 0) begin
                m = 4'(mi);
                n = 4'(ni);
            end else begin
                m = 4'($urandom_range(0, 15));
                n = 4'($urandom_range(0, 15));
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 3 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (v && out_ready) begin
                acc++;
                last_hs = k;
            end
            stall = v && !out_ready;
            pd    = d;
            pl    = l;
            end_k = (total > 0) ? last_hs + 1 : 1;
            if (acc >= total && k >= end_k + 2) break;
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_count", 32'(dones), 1);
        chk("beat_count", 32'(acc), 32'(total));
        beats = acc;
    endtask

    vec_t vecs[6];

    initial begin
        int beats;
        int dcyc;
        int rm;
        int rn;

        vecs[0] = '{2,  3,  0, -1, 6,   9,   "2x3_ready"};
        vecs[1] = '{2,  3,  1, -1, 6,   19,  "2x3_toggle"};
        vecs[2] = '{0,  5,  0, -1, 0,   1,   "0x5_empty"};
        vecs[3] = '{15, 15, 0, -1, 225, 228, "15x15_full"};
        vecs[4] = '{2,  3,  0, 4,  6,   9,   "2x3_restart"};
        vecs[5] = '{1,  1,  0, -1, 1,   4,   "1x1_single"};

        for (int i = 0; i < 256; i++) gbuf[i] = 16'(100 + i);

        rst = 1'b0;
        start = 1'b0;
        m = '0;
        n = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        zero_chk("reset");
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            tag = vecs[i].name;
            run_drain(vecs[i].m, vecs[i].n, vecs[i].mode, vecs[i].extra, beats, dcyc);
            chk("table_beats", 32'(beats), 32'(vecs[i].exp_beats));
            if (vecs[i].exp_done >= 0) chk("table_done_cycle", 32'(dcyc), 32'(vecs[i].exp_done));
        end

        // Abort a 3x3 drain with reset in cycle 5, release in cycle 7, then a fresh 1x2 drain.
        tag = "abort";
        @(negedge clk);
        start = 1'b1;
        m = 4'd3;
        n = 4'd3;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        zero_chk("abort_c5");
        @(negedge clk);
        zero_chk("abort_c6");
        @(negedge clk);
        zero_chk("abort_c7");
        rst = 1'b1;
        @(negedge clk);
        tag = "after_abort";
        run_drain(1, 2, 0, -1, beats, dcyc);
        chk("after_abort_done_cycle", 32'(dcyc), 5);

        // Random drains against the ordered-list model with random backpressure.
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 256; i++) gbuf[i] = 16'($urandom);
            rm = (r == 0) ? 15 : int'($urandom_range(0, 15));
            rn = (r == 0) ? 15 : int'($urandom_range(0, 15));
            tag = $sformatf("rand%0d_%0dx%0d", r, rm, rn);
            run_drain(rm, rn, 2, -1, beats, dcyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/result_drain.md
# result_drain

Downstream stage of the TPU: once a matrix multiply completes, it reads the m×n result matrix out of the output global buffer (`EXTEND_WORD_SIZE`-wide words) and streams it on a valid/ready interface. It sits between GBUFF_OUT and the host/DMA side. It owns GBUFF_OUT's read port only while busy. Top-level muxing gives it `index`, with `wr_en` forced low, when `busy` is high.

## Interface
- DATA_W, default `EXTEND_WORD_SIZE`: result word width.
- IDX_W, default `GBUFF_INDX_SIZE`: buffer index width.
- FIFO_DEPTH, default 2: output FIFO entries. Must be ≥2 for full throughput.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a drain; sampled only in IDLE.
- m  in  4  result rows, latched at start.
- n  in  4  result columns, latched at start.
- gb_index  out  IDX_W  GBUFF_OUT read index.
- gb_wr_en  out  1  constant 0.
- gb_data  in  DATA_W  GBUFF_OUT data_out, valid the cycle after gb_index is driven.
- out_data  out  DATA_W  stream payload, head of FIFO.
- out_valid  out  1  payload valid.
- out_ready  in  1  consumer accepts when high with out_valid.
- out_last  out  1  high with the final beat (index m*n-1).
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- Result layout is row-major. Word (i,j) is at index i*n+j. total = m*n, range 0..225, held in an 8-bit register.
- FSM states:
  - IDLE: start → DRAIN when total≠0, or DONE when total=0. Latch total and clear the counters.
  - DRAIN: issue reads. When the read for index total-1 is issued → FLUSH.
  - FLUSH: no reads issued. When the FIFO is empty and no read is in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Read issue rule (credit based):
  - rd_issue = (state==DRAIN) && (fifo_count + inflight − pop) < FIFO_DEPTH.
  - pop = out_valid && out_ready.
  - inflight is a 1-bit register equal to the previous cycle's rd_issue.
- gb_index equals the registered rd_ptr. rd_ptr increments on rd_issue. When no read is issued, gb_index holds its last value, which is harmless.
- FIFO push = inflight, capturing gb_data. Push and pop in the same cycle are legal at any occupancy the credit rule allows.
- beat_cnt increments on pop. out_last = out_valid && (beat_cnt == total−1).
- A start pulse seen while not in IDLE is ignored. m and n changes after start have no effect.
- Reset values: state IDLE; all counters 0; FIFO empty; out_valid, out_last, busy, done, gb_wr_en all 0; gb_index 0; out_data 0.
- Reset asserted mid-drain aborts immediately:
  - The FIFO is flushed and no done pulse is produced.
  - The next start begins from index 0.

## Timing
- Accepted start in cycle 0 → state DRAIN and busy=1 in cycle 1, with the first read (index 0) issued that cycle.
- Data returns in cycle 2 and is pushed at the end of cycle 2. out_valid=1 in cycle 3 (latency 3).
- With out_ready held high, throughput is 1 beat/cycle: beat k is presented in cycle 3+k.
- done is asserted the cycle after the last handshake, and busy drops in that same cycle.
- With total=0: busy=1 in cycle 1 (state DONE), done=1 in cycle 1, no beats produced.
- Under backpressure:
  - out_data, out_valid and out_last hold stable until accepted.
  - No FIFO overflow may occur; the credit rule guarantees this.
  - At most FIFO_DEPTH words are buffered or in flight.

## Structure
- Widths `EXTEND_WORD_SIZE` and `GBUFF_INDX_SIZE` come from define.v. Add `DRAIN_IDLE`, `DRAIN_RUN`, `DRAIN_FLUSH` and `DRAIN_DONE` state encodings there.
- Sub-module `drain_fifo`:
  - Synchronous FIFO with parameterised depth/width and the same async active-low reset.
  - Outputs count, empty and full.
  - Head is visible combinationally (first-word-fall-through).
- result_drain holds the FSM, rd_ptr, inflight, beat_cnt and total.

## Test plan
- m=2, n=3, GBUFF_OUT[i]=100+i, out_ready=1, start in cycle 0 → beats 100..105 in cycles 3..8; out_last only on 105; done in cycle 9; busy cycles 1..8.
- Same setup, out_ready toggling 1,0,0,1… → same six values in order; each beat held stable while stalled; FIFO count never exceeds 2; done one cycle after the final handshake.
- m=0, n=5, start → no out_valid ever; done=1 exactly in cycle 1; gb_index never advances.
- m=15, n=15, out_ready=1 → 225 beats with indices 0..224 in order; out_last on beat 224; no gaps after the first beat.
- Second start pulse in cycle 4 of a 2×3 drain → ignored; exactly 6 beats and one done pulse.
- rst driven low in cycle 5 of a 3×3 drain, released in cycle 7, then a new 1×2 start → all outputs 0 during reset; the new drain yields indices 0 and 1 only; no stale beats.
